column_scroller: RTL and testbench

- Upstream feeder for the 4-column x 8-row LED matrix driver. Drives that driver's frame inputs leds1..leds4 and leds_pwm.
- Accepts 8-bit column bitmaps over a valid/ready stream and buffers them in a small FIFO.
- Scrolls buffered columns across the display, one column every TICK_DIV clocks; new columns enter at leds4 and move toward leds1.
- After the stream runs dry, scrolls blanks until the display is empty, then idles.

---
 rtl/led_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/column_scroller.sv | 168 ++++++++++++++++
 tb/tb_column_scroller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED matrix feed path.
// Geometry, PWM width and the column scroller state encoding.
package led_pkg;

    localparam int COLS    = 4;
    localparam int ROWS    = 8;
    localparam int PWM_W   = 3;
    localparam int BLANK_W = 3;

    localparam logic [PWM_W-1:0]   PWM_MAX   = 3'd7;
    localparam logic [BLANK_W-1:0] BLANK_END = BLANK_W'(COLS);

    typedef logic [ROWS-1:0] col_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level, full and empty flags.
// No write-to-read bypass: a pushed entry is poppable on the next cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/column_scroller.sv
// Feeds the 4x8 LED matrix driver: buffers incoming columns and
// scrolls them right-to-left, one column per TICK_DIV clocks.
module column_scroller
    import led_pkg::*;
#(
    parameter  int TICK_DIV   = 1200000,
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk12MHz,
    input  logic             reset,
    input  logic [7:0]       col_data,
    input  logic             col_valid,
    output logic             col_ready,
    input  logic             pause,
    input  logic [2:0]       brightness,
    output logic [7:0]       leds1,
    output logic [7:0]       leds2,
    output logic [7:0]       leds3,
    output logic [7:0]       leds4,
    output logic [2:0]       leds_pwm,
    output logic [LVL_W-1:0] fifo_level,
    output logic             underrun
);

    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    col_t               l1_q, l1_d;
    col_t               l2_q, l2_d;
    col_t               l3_q, l3_d;
    col_t               l4_q, l4_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic               underrun_q, underrun_d;

    logic               fifo_push;
    logic               fifo_pop;
    col_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               tick;
    logic               shift;

    assign fifo_push = col_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (ROWS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk12MHz),
        .rst   (reset),
        .push  (fifo_push),
        .wdata (col_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blank_d    = blank_q;
        l1_d       = l1_q;
        l2_d       = l2_q;
        l3_d       = l3_q;
        l4_d       = l4_q;
        pwm_d      = pwm_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        shift      = 1'b0;
        tick       = (cnt_q == TICK_LAST);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty && !pause) begin
                    fifo_pop = 1'b1;
                    shift    = 1'b1;
                    state_d  = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (!pause) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        shift = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            blank_d    = BLANK_W'(1);
                            state_d    = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!pause) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        shift = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            blank_d  = '0;
                            state_d  = ST_SCROLL;
                        end else if (blank_q + 1'b1 == BLANK_END) begin
                            blank_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            blank_d = blank_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Brightness is latched only at column boundaries.
        if (shift) begin
            l1_d  = l2_q;
            l2_d  = l3_q;
            l3_d  = l4_q;
            l4_d  = fifo_pop ? fifo_head : '0;
            pwm_d = brightness;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            blank_q    <= '0;
            l1_q       <= '0;
            l2_q       <= '0;
            l3_q       <= '0;
            l4_q       <= '0;
            pwm_q      <= PWM_MAX;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blank_q    <= blank_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
            l3_q       <= l3_d;
            l4_q       <= l4_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    assign col_ready = !fifo_full;
    assign leds1     = l1_q;
    assign leds2     = l2_q;
    assign leds3     = l3_q;
    assign leds4     = l4_q;
    assign leds_pwm  = pwm_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_column_scroller.sv
// Scoreboard bench for column_scroller: expected frames and underrun
// cycles are queued by the stimulus and checked by a negedge monitor.
module tb_column_scroller;

    logic       clk12MHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] col_data = 8'h00;
    logic       col_valid = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] brightness = 3'd7;
    logic       col_ready;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic [2:0] leds_pwm;
    logic [3:0] fifo_level;
    logic       underrun;

    column_scroller #(
        .TICK_DIV   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk12MHz   (clk12MHz),
        .reset      (reset),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .pause      (pause),
        .brightness (brightness),
        .leds1      (leds1),
        .leds2      (leds2),
        .leds3      (leds3),
        .leds4      (leds4),
        .leds_pwm   (leds_pwm),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    always #5 clk12MHz = ~clk12MHz;

    int cyc = 0;
    always @(posedge clk12MHz) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [34:0] f;
    } exp_t;

    exp_t        fq[$];
    int          uq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        mon_en = 1'b0;
    logic [34:0] prev_f = {32'h0, 3'd7};
    logic [34:0] cur_f;
    exp_t        e_m;
    int          u_m;

    assign cur_f = {leds1, leds2, leds3, leds4, leds_pwm};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic goto(input int n);
        if (cyc > n) begin
            n_chk++;
            $display("FAIL sched: at cycle %0d, target %0d", cyc, n);
        end
        while (cyc < n) begin
            @(posedge clk12MHz);
            #1;
        end
    endtask

    task automatic ef(input int c, input logic [31:0] f, input logic [2:0] p);
        exp_t e;
        e.c = c;
        e.f = {f, p};
        fq.push_back(e);
    endtask

    always @(negedge clk12MHz) begin
        if (mon_en) begin
            if (cur_f !== prev_f) begin
                n_chk++;
                if (fq.size() == 0) begin
                    $display("FAIL frame: unexpected %h at cycle %0d", cur_f, cyc);
                end else begin
                    e_m = fq.pop_front();
                    if (e_m.c == cyc && e_m.f === cur_f) n_pass++;
                    else $display("FAIL frame: got %h at cycle %0d, expected %h at cycle %0d",
                                  cur_f, cyc, e_m.f, e_m.c);
                end
                prev_f = cur_f;
            end
            if (underrun !== 1'b0) begin
                n_chk++;
                if (uq.size() == 0) begin
                    $display("FAIL underrun: unexpected pulse at cycle %0d", cyc);
                end else begin
                    u_m = uq.pop_front();
                    if (u_m == cyc && underrun === 1'b1) n_pass++;
                    else $display("FAIL underrun: got pulse at cycle %0d, expected cycle %0d",
                                  cyc, u_m);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int r;
        int acc;
        logic last_rdy;

        // reset with valid held high
        col_valid = 1'b1;
        col_data  = 8'hFF;
        repeat (3) @(posedge clk12MHz);
        #1;
        chk("reset_leds", {leds1, leds2, leds3, leds4}, 0);
        chk("reset_pwm", leds_pwm, 7);
        chk("reset_level", fifo_level, 0);
        chk("reset_ready", col_ready, 1);
        chk("reset_underrun", underrun, 0);
        reset     = 1'b0;
        col_valid = 1'b0;
        mon_en    = 1'b1;
        goto(cyc + 1);
        chk("reset_no_push", fifo_level, 0);

        // single column A5
        b = cyc;
        ef(b + 2,  32'h000000A5, 3'd7);
        ef(b + 6,  32'h0000A500, 3'd7);
        ef(b + 10, 32'h00A50000, 3'd7);
        ef(b + 14, 32'hA5000000, 3'd7);
        ef(b + 18, 32'h00000000, 3'd7);
        uq.push_back(b + 6);
        col_data  = 8'hA5;
        col_valid = 1'b1;
        goto(b + 1);
        col_valid = 1'b0;
        chk("single_level_push", fifo_level, 1);
        goto(b + 2);
        chk("single_level_pop", fifo_level, 0);
        goto(b + 22);

        // fill while paused
        pause    = 1'b1;
        acc      = 0;
        last_rdy = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            col_data  = 8'(i);
            col_valid = 1'b1;
            last_rdy  = col_ready;
            if (col_ready) acc++;
            goto(cyc + 1);
        end
        col_valid = 1'b0;
        chk("fill_accepts", acc, 8);
        chk("fill_ready_9th", last_rdy, 0);
        chk("fill_level", fifo_level, 8);
        chk("fill_ready", col_ready, 0);

        r = cyc;
        ef(r + 1,  32'h00000001, 3'd7);
        ef(r + 5,  32'h00000102, 3'd7);
        ef(r + 9,  32'h00010203, 3'd7);
        ef(r + 13, 32'h01020304, 3'd7);
        ef(r + 27, 32'h02030405, 3'd7);
        ef(r + 31, 32'h03040506, 3'd7);
        ef(r + 35, 32'h04050607, 3'd7);
        ef(r + 39, 32'h05060708, 3'd7);
        ef(r + 43, 32'h06070800, 3'd7);
        ef(r + 47, 32'h07080000, 3'd7);
        ef(r + 51, 32'h0800003C, 3'd2);
        ef(r + 55, 32'h00003C00, 3'd2);
        ef(r + 59, 32'h003C0000, 3'd2);
        ef(r + 63, 32'h3C000000, 3'd2);
        ef(r + 67, 32'h00000000, 3'd2);
        uq.push_back(r + 43);
        uq.push_back(r + 55);
        pause = 1'b0;
        goto(r + 1);
        chk("drain_level_1", fifo_level, 7);
        chk("drain_ready", col_ready, 1);
        goto(r + 5);
        chk("drain_level_2", fifo_level, 6);
        goto(r + 9);
        chk("drain_level_3", fifo_level, 5);
        goto(r + 13);
        chk("drain_level_4", fifo_level, 4);

        // pause at count 2 for 10 cycles
        goto(r + 15);
        pause = 1'b1;
        goto(r + 25);
        pause = 1'b0;
        chk("pause_level_held", fifo_level, 4);
        goto(r + 27);
        chk("pause_resume_level", fifo_level, 3);

        // recovery from DRAIN with blank_cnt=2
        goto(r + 47);
        col_data  = 8'h3C;
        col_valid = 1'b1;
        goto(r + 48);
        col_valid = 1'b0;
        chk("recover_level", fifo_level, 1);
        goto(r + 49);
        brightness = 3'd2;
        goto(r + 50);
        chk("pwm_before_shift", leds_pwm, 7);
        goto(r + 51);
        chk("pwm_after_shift", leds_pwm, 2);
        chk("recover_level_pop", fifo_level, 0);

        goto(r + 72);
        chk("final_leds", {leds1, leds2, leds3, leds4}, 0);
        chk("frames_left", fq.size(), 0);
        chk("underruns_left", uq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
